// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared constants for the Phase 2 CPU control path: the control-sequencer
// state encoding, the instruction opcodes and a helper that tells whether an
// opcode is one of the three-register ALU instructions. The select-and-encode
// logic and the ALU import this package for the opcode constants.
package cpu_ctrl_pkg;

  // Sequencer states. RESET and HALT are the only non-running states.
  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_T0    = 3'd1,
    S_T1    = 3'd2,
    S_T2    = 3'd3,
    S_T3    = 3'd4,
    S_T4    = 3'd5,
    S_T5    = 3'd6,
    S_HALT  = 3'd7
  } state_t;

  // Opcodes live in IR[31:27].
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // The supported ALU opcodes form one contiguous range, ADD through OR.
  function automatic logic is_alu_op(input logic [4:0] op);
    return (op >= OP_ADD) && (op <= OP_OR);
  endfunction

endpackage

// File: rtl/control_unit.sv
// control_unit
// Hardwired control sequencer. Fetches an instruction in T0-T2, then executes
// a three-register ALU instruction in T3-T5 (Rb -> Y, Y op Rc -> ZLO,
// ZLO -> Ra). HALT or any unsupported opcode parks the sequencer in HALT from
// T3; only Clear low leaves HALT.
//
// Ports
//   Clock                 system clock, rising edge
//   Clear                 synchronous active-low reset
//   IR[31:0]              instruction register from the Datapath, opcode in [31:27]
//   Stop                  halt request, sampled only at the edge ending T5
//   Run                   1 in T0-T5
//   PC_Out/MAR_In/IncPC/PC_In        PC and MAR strobes
//   Read/MDR_In/MDR_Out/IR_In        memory read and IR load strobes
//   Y_In/ZLO_In/ZLO_Out              ALU operand and result strobes
//   Gra/Grb/Grc/R_In/R_Out           register field select and direction
//   CONTROL[4:0]          ALU operation, nonzero only in T4
//   state_o               current sequencer state (debug)
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        Stop,
  output logic        Run,
  output logic        PC_Out,
  output logic        MAR_In,
  output logic        IncPC,
  output logic        PC_In,
  output logic        Read,
  output logic        MDR_In,
  output logic        MDR_Out,
  output logic        IR_In,
  output logic        Y_In,
  output logic        ZLO_In,
  output logic        ZLO_Out,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        R_In,
  output logic        R_Out,
  output logic [4:0]  CONTROL,
  output state_t      state_o
);

  state_t     state_q, state_d;
  logic [4:0] opcode;
  logic       ir_fields_unused;

  assign opcode = IR[31:27];
  // Register fields are consumed by the select-and-encode logic, not here.
  assign ir_fields_unused = ^IR[26:0];

  // Next-state logic. IR is only meaningful from T3 on (loaded at the edge
  // ending T2), so the opcode is only looked at in T3.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3:    state_d = is_alu_op(opcode) ? S_T4 : S_HALT;
      S_T4:    state_d = S_T5;
      S_T5:    state_d = Stop ? S_HALT : S_T0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

  // Moore output decode: strobes follow the current state; IR only matters
  // in T3 (supported or not) and T4 (ALU operation).
  always_comb begin
    Run     = 1'b0;
    PC_Out  = 1'b0;
    MAR_In  = 1'b0;
    IncPC   = 1'b0;
    PC_In   = 1'b0;
    Read    = 1'b0;
    MDR_In  = 1'b0;
    MDR_Out = 1'b0;
    IR_In   = 1'b0;
    Y_In    = 1'b0;
    ZLO_In  = 1'b0;
    ZLO_Out = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    R_In    = 1'b0;
    R_Out   = 1'b0;
    CONTROL = 5'd0;
    unique case (state_q)
      S_T0: begin
        Run    = 1'b1;
        PC_Out = 1'b1;
        MAR_In = 1'b1;
        IncPC  = 1'b1;
        ZLO_In = 1'b1;
      end
      S_T1: begin
        Run     = 1'b1;
        ZLO_Out = 1'b1;
        PC_In   = 1'b1;
        Read    = 1'b1;
        MDR_In  = 1'b1;
      end
      S_T2: begin
        Run     = 1'b1;
        MDR_Out = 1'b1;
        IR_In   = 1'b1;
      end
      S_T3: begin
        Run = 1'b1;
        if (is_alu_op(opcode)) begin
          Grb   = 1'b1;
          R_Out = 1'b1;
          Y_In  = 1'b1;
        end
      end
      S_T4: begin
        Run     = 1'b1;
        Grc     = 1'b1;
        R_Out   = 1'b1;
        ZLO_In  = 1'b1;
        CONTROL = opcode;
      end
      S_T5: begin
        Run     = 1'b1;
        ZLO_Out = 1'b1;
        Gra     = 1'b1;
        R_In    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
// Drives the control sequencer cycle by cycle. A reference model tracks which
// step of an instruction the sequencer should be in and pushes the expected
// output word for every cycle into exp_q; a monitor on the falling edge pops
// and compares against the DUT outputs.
module tb_control_unit;
  import cpu_ctrl_pkg::*;

  logic        Clock;
  logic        Clear;
  logic [31:0] IR;
  logic        Stop;
  logic        Run, PC_Out, MAR_In, IncPC, PC_In, Read, MDR_In, MDR_Out, IR_In;
  logic        Y_In, ZLO_In, ZLO_Out, Gra, Grb, Grc, R_In, R_Out;
  logic [4:0]  CONTROL;
  state_t      state_o;

  control_unit dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .Stop(Stop), .Run(Run),
    .PC_Out(PC_Out), .MAR_In(MAR_In), .IncPC(IncPC), .PC_In(PC_In),
    .Read(Read), .MDR_In(MDR_In), .MDR_Out(MDR_Out), .IR_In(IR_In),
    .Y_In(Y_In), .ZLO_In(ZLO_In), .ZLO_Out(ZLO_Out), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .R_In(R_In), .R_Out(R_Out), .CONTROL(CONTROL), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // ---------------- reference model ----------------
  // m_step: 0 = in reset, 1..6 = instruction step T0..T5, 7 = halted.
  localparam int M_RESET = 0;
  localparam int M_HALT  = 7;

  int checks   = 0;
  int failures = 0;
  int m_step   = M_RESET;

  // Output word: {Run, PC_Out, MAR_In, IncPC, PC_In, Read, MDR_In, MDR_Out,
  //               IR_In, Y_In, ZLO_In, ZLO_Out, Gra, Grb, Grc, R_In, R_Out, CONTROL}
  logic [21:0] exp_q[$];

  function automatic bit model_alu(input logic [31:0] ir);
    int op;
    op = int'(ir[31:27]);
    return (op >= 3) && (op <= 10);
  endfunction

  function automatic logic [21:0] model_out(input int step, input logic [31:0] ir);
    logic run, pco, mari, inc, pci, rd, mdri, mdro, iri, yi, zi, zo;
    logic ga, gb, gc, ri, ro;
    logic [4:0] ctl;
    {run, pco, mari, inc, pci, rd, mdri, mdro, iri, yi, zi, zo} = '0;
    {ga, gb, gc, ri, ro} = '0;
    ctl = '0;
    run = (step >= 1) && (step <= 6);
    case (step)
      1: begin pco = 1; mari = 1; inc = 1; zi = 1; end
      2: begin zo = 1; pci = 1; rd = 1; mdri = 1; end
      3: begin mdro = 1; iri = 1; end
      4: if (model_alu(ir)) begin gb = 1; ro = 1; yi = 1; end
      5: begin gc = 1; ro = 1; zi = 1; ctl = ir[31:27]; end
      6: begin zo = 1; ga = 1; ri = 1; end
      default: ;
    endcase
    return {run, pco, mari, inc, pci, rd, mdri, mdro, iri, yi, zi, zo,
            ga, gb, gc, ri, ro, ctl};
  endfunction

  function automatic int model_next(input int step, input bit clr, input bit stp,
                                    input logic [31:0] ir);
    if (!clr) return M_RESET;
    case (step)
      M_RESET: return 1;
      1, 2, 3: return step + 1;
      4:       return model_alu(ir) ? 5 : M_HALT;
      5:       return 6;
      6:       return stp ? M_HALT : 1;
      default: return M_HALT;
    endcase
  endfunction

  // ---------------- driver ----------------
  // One cycle: inputs applied shortly after the rising edge. The new
  // instruction word appears on IR at the start of T3, as the Datapath's IR
  // is loaded at the edge ending T2.
  task automatic cyc(input bit clr, input bit stp, input logic [31:0] ir_next);
    Clear = clr;
    Stop  = stp;
    if (m_step == 4) IR = ir_next;
    exp_q.push_back(model_out(m_step, IR));
    m_step = model_next(m_step, clr, stp, IR);
    @(posedge Clock);
    #1;
  endtask

  // Full six-step instruction; Stop asserted only in the chosen step (0 = none).
  task automatic run_instr(input logic [31:0] ir, input int stop_step);
    for (int s = 1; s <= 6; s++) cyc(1'b1, (s == stop_step), ir);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] op;
    logic [4:0] alu_ops [8];
    alu_ops = '{OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR};
    if ($urandom_range(0, 9) < 8) op = alu_ops[$urandom_range(0, 7)];
    else op = 5'($urandom_range(0, 31));
    return {op, 27'($urandom())};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge Clock) begin
    logic [21:0] act, exp_w;
    if (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      act = {Run, PC_Out, MAR_In, IncPC, PC_In, Read, MDR_In, MDR_Out, IR_In,
             Y_In, ZLO_In, ZLO_Out, Gra, Grb, Grc, R_In, R_Out, CONTROL};
      checks++;
      if (act !== exp_w) begin
        failures++;
        $display("FAIL outputs t=%0t actual=%b required=%b", $time, act, exp_w);
      end
      checks++;
      if ((R_In || R_Out) && (int'(Gra) + int'(Grb) + int'(Grc) != 1 || (R_In && R_Out))) begin
        failures++;
        $display("FAIL reg_select t=%0t actual Gra/Grb/Grc/R_In/R_Out=%b%b%b%b%b required one-hot select, single direction",
                 $time, Gra, Grb, Grc, R_In, R_Out);
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [31:0] IR_AND  = 32'h4A920000;
  localparam logic [31:0] IR_ADD  = 32'h1A920000;
  localparam logic [31:0] IR_SUB  = 32'h22920000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;
  localparam logic [31:0] IR_BAD  = 32'hF8000000;

  initial begin
    int budget;
    Clear = 1'b0;
    Stop  = 1'b0;
    IR    = 32'h0;
    @(posedge Clock);
    #1;
    m_step = M_RESET;

    // Reset held low for three cycles, then release: RESET once, then T0.
    repeat (3) cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    run_instr(IR_AND, 0);
    // Back-to-back ADD then SUB; Stop at T5 of SUB halts.
    run_instr(IR_ADD, 0);
    run_instr(IR_SUB, 6);
    repeat (3) cyc(1'b1, 1'b0, 32'h0);

    // HALT opcode: T0..T3 then HALT, stays halted.
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    for (int s = 1; s <= 4; s++) cyc(1'b1, 1'b0, IR_HALT);
    repeat (10) cyc(1'b1, 1'b0, 32'h0);

    // Unsupported opcode with Stop high throughout: opcode wins at T3.
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h0);
    for (int s = 1; s <= 4; s++) cyc(1'b1, 1'b1, IR_BAD);
    repeat (10) cyc(1'b1, 1'b0, 32'h0);

    // Stop pulsed in T2 only is ignored; Stop at T5 halts.
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    run_instr(IR_ADD, 3);
    run_instr(IR_SUB, 6);
    repeat (2) cyc(1'b1, 1'b0, 32'h0);

    // Clear low during T4 aborts the instruction before any T5 write.
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    for (int s = 1; s <= 4; s++) cyc(1'b1, 1'b0, IR_AND);
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    run_instr(IR_OR_word(), 0);

    // Randomized traffic: random instructions, Stop and occasional Clear.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ir_r;
      bit clr_r, stp_r;
      ir_r  = rand_instr();
      stp_r = ($urandom_range(0, 5) == 0);
      clr_r = !($urandom_range(0, 39) == 0);
      if (m_step == M_HALT && $urandom_range(0, 7) == 0) clr_r = 1'b0;
      cyc(clr_r, stp_r, ir_r);
    end

    // Drain the scoreboard with a bounded wait.
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge Clock);
      budget--;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic [31:0] IR_OR_word();
    return {OP_OR, 27'h0123456};
  endfunction

endmodule
